// File: rtl/fpu_pkg.sv
// Shared types, constants and operand classification for the binary32 add/sub/mul pipeline.
package fpu_pkg;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int LATENCY = 2;
  // Datapath significand: two integer bits (carry + hidden) above the binary point.
  localparam int SIG_W   = 48;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} fclass_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } fpu_req_t;

  // Exponent 0 counts as zero: denormals are flushed.
  function automatic fclass_e fclass(input logic [31:0] x);
    fclass_e c;
    if (x[30:23] == 8'h00)      c = CL_ZERO;
    else if (x[30:23] == 8'hFF) c = (x[22:0] == '0) ? CL_INF : CL_NAN;
    else                        c = CL_NORM;
    return c;
  endfunction
endpackage

// File: rtl/fpu_norm_round.sv
// Leading-zero normalise, round-to-nearest-even and overflow/underflow clamp.
module fpu_norm_round
  import fpu_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] uexp,
  input  logic [SIG_W-1:0]  sig,
  output logic [31:0]       res
);
  localparam int G = SIG_W - FRAC_W - 2;
  localparam logic signed [11:0] EOFF = 12'(BIAS + 1);

  logic [5:0]             lz;
  logic [SIG_W-1:0]       norm;
  logic                   rnd;
  logic [FRAC_W+1:0]      mant_r;
  logic signed [11:0]     e_biased;

  always_comb begin
    lz = '0;
    for (int i = 0; i < SIG_W; i++)
      if (sig[i]) lz = 6'(SIG_W - 1 - i);
  end

  assign norm   = sig << lz;
  assign rnd    = norm[G] & (norm[G+1] | (|norm[G-1:0]));
  assign mant_r = {1'b0, 1'b1, norm[SIG_W-2 -: FRAC_W]} + (FRAC_W+2)'(rnd);
  // A rounding carry leaves the fraction all-zero and bumps the exponent.
  assign e_biased = {{2{uexp[9]}}, uexp} + EOFF - $signed({6'b0, lz})
                  + $signed({11'b0, mant_r[FRAC_W+1]});

  always_comb begin
    if (sig == '0)                res = {sign, 31'b0};
    else if (e_biased > 12'sd254) res = {sign, 8'hFF, 23'b0};
    else if (e_biased < 12'sd1)   res = {sign, 31'b0};
    else                          res = {sign, e_biased[7:0], mant_r[FRAC_W-1:0]};
  end
endmodule

// File: rtl/fpu_core.sv
// Two-stage binary32 add/sub/mul: operands registered, then result registered into O.
module fpu_core
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  opcode,
  output logic [31:0] O
);
  fpu_req_t          req;
  fclass_e           ca, cb;
  logic              sa, sb, a_big, eff_sub, add_sign, mul_sign;
  logic [7:0]        ea, eb, e_big, e_small, d;
  logic [4:0]        dsh;
  logic [23:0]       ma, mb, m_big, m_small;
  logic [53:0]       al;
  logic [26:0]       big27, small27;
  logic [27:0]       mag;
  logic [47:0]       prod;
  logic signed [9:0] add_e, mul_e, nr_e;
  logic              nr_sign;
  logic [SIG_W-1:0]  nr_sig;
  logic [31:0]       nr_res, res;

  always_ff @(posedge clk) begin
    if (rst) begin
      req <= '0;
      O   <= '0;
    end else begin
      req <= '{a: A, b: B, op: opcode};
      O   <= res;
    end
  end

  assign ca = fclass(req.a);
  assign cb = fclass(req.b);
  assign sa = req.a[31];
  assign sb = req.b[31] ^ (req.op == OP_SUB);
  assign ea = req.a[30:23];
  assign eb = req.b[30:23];
  assign ma = (ca == CL_ZERO) ? 24'd0 : {1'b1, req.a[22:0]};
  assign mb = (cb == CL_ZERO) ? 24'd0 : {1'b1, req.b[22:0]};

  // Add/sub: align smaller magnitude with guard/round/sticky; shifts >= 27 collapse to sticky.
  assign a_big   = {ea, ma} >= {eb, mb};
  assign e_big   = a_big ? ea : eb;
  assign e_small = a_big ? eb : ea;
  assign m_big   = a_big ? ma : mb;
  assign m_small = a_big ? mb : ma;
  assign d       = e_big - e_small;
  assign dsh     = (d > 8'd27) ? 5'd27 : d[4:0];
  assign al      = {m_small, 30'b0} >> dsh;
  assign small27 = {al[53:28], al[27] | (|al[26:0])};
  assign big27   = {m_big, 3'b0};
  assign eff_sub = sa ^ sb;
  assign mag     = eff_sub ? ({1'b0, big27} - {1'b0, small27})
                           : ({1'b0, big27} + {1'b0, small27});
  assign add_sign = (mag == '0) ? (sa & sb) : (a_big ? sa : sb);
  assign add_e    = $signed({2'b0, e_big}) - 10'sd127;

  assign prod     = 48'(ma) * 48'(mb);
  assign mul_sign = sa ^ req.b[31];
  assign mul_e    = $signed({2'b0, ea}) + $signed({2'b0, eb}) - 10'sd254;

  assign nr_sign = req.op[1] ? mul_sign : add_sign;
  assign nr_e    = req.op[1] ? mul_e : add_e;
  assign nr_sig  = req.op[1] ? prod : {mag, 20'b0};

  fpu_norm_round u_nr (
    .sign (nr_sign),
    .uexp (nr_e),
    .sig  (nr_sig),
    .res  (nr_res)
  );

  always_comb begin
    res = nr_res;
    case (req.op)
      OP_ADD, OP_SUB: begin
        if (ca == CL_NAN || cb == CL_NAN)      res = QNAN;
        else if (ca == CL_INF && cb == CL_INF) res = (sa != sb) ? QNAN : {sa, POS_INF[30:0]};
        else if (ca == CL_INF)                 res = {sa, POS_INF[30:0]};
        else if (cb == CL_INF)                 res = {sb, POS_INF[30:0]};
      end
      OP_MUL: begin
        if (ca == CL_NAN || cb == CL_NAN)                   res = QNAN;
        else if ((ca == CL_INF && cb == CL_ZERO) ||
                 (cb == CL_INF && ca == CL_ZERO))           res = QNAN;
        else if (ca == CL_INF || cb == CL_INF)              res = {mul_sign, POS_INF[30:0]};
        else if (ca == CL_ZERO || cb == CL_ZERO)            res = {mul_sign, 31'b0};
      end
      default: res = '0;
    endcase
  end
endmodule

// File: tb/tb_fpu_core.sv
// Directed-vector bench for fpu_core: reset, arithmetic, specials, streaming and mid-stream reset.
module tb_fpu_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B, O;
  logic [1:0]  opcode;
  int checks = 0;
  int errors = 0;

  fpu_core dut (.clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .O(O));

  always #5 clk = ~clk;

  // Drive one operation and return O two edges later, sampled 1 time unit after the edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        output logic [31:0] o);
    A = a; B = b; opcode = op;
    @(posedge clk); #1;
    @(posedge clk); #1;
    o = O;
  endtask

  task automatic test_reset();
    rst = 1'b1; A = 32'h3F800000; B = 32'h3F800000; opcode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (O !== 32'h00000000) begin
      errors++; $display("FAIL reset_state: got %h want 00000000", O);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_tiny();
    logic [31:0] a [4] = '{32'hF45315F9, 32'h4881D979, 32'h876A2882, 32'h0401E6D9};
    logic [31:0] b [4] = '{32'h21A8735A, 32'h0D5A3696, 32'h45FD9E91, 32'h3D3E3FCF};
    logic [31:0] e [4] = '{32'hF45315F9, 32'h4881D979, 32'h45FD9E91, 32'h3D3E3FCF};
    logic [31:0] o;
    int diff;
    for (int i = 0; i < 4; i++) begin
      run_op(a[i], b[i], 2'b00, o);
      diff = (o > e[i]) ? int'(o - e[i]) : int'(e[i] - o);
      checks++;
      if (diff > 2) begin
        errors++; $display("FAIL add_tiny[%0d]: got %h want %h", i, o, e[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] a  [5] = '{32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h80000000};
    logic [31:0] b  [5] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h80000000};
    logic [1:0]  op [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
    logic [31:0] e  [5] = '{32'h40000000, 32'h00000000, 32'h40400000, 32'h3F800000, 32'h80000000};
    logic [31:0] o;
    for (int i = 0; i < 5; i++) begin
      run_op(a[i], b[i], op[i], o);
      checks++;
      if (o !== e[i]) begin
        errors++; $display("FAIL basic[%0d]: got %h want %h", i, o, e[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] a  [6] = '{32'h7F800000, 32'h7F000000, 32'h00800000, 32'h3F800000,
                            32'h7FC12345, 32'h7F800000};
    logic [31:0] b  [6] = '{32'hFF800000, 32'h40000000, 32'h00800000, 32'h3F800000,
                            32'h3F800000, 32'h00000000};
    logic [1:0]  op [6] = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b00, 2'b10};
    logic [31:0] e  [6] = '{32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h00000000,
                            32'h7FC00000, 32'h7FC00000};
    logic [31:0] o;
    for (int i = 0; i < 6; i++) begin
      run_op(a[i], b[i], op[i], o);
      checks++;
      if (o !== e[i]) begin
        errors++; $display("FAIL special[%0d]: got %h want %h", i, o, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a  [3] = '{32'h3F800000, 32'h3FC00000, 32'h40000000};
    logic [31:0] b  [3] = '{32'h3F800000, 32'h40000000, 32'h3F800000};
    logic [1:0]  op [3] = '{2'b00, 2'b10, 2'b01};
    logic [31:0] e  [3] = '{32'h40000000, 32'h40400000, 32'h3F800000};
    A = a[0]; B = b[0]; opcode = op[0];
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin A = a[i+1]; B = b[i+1]; opcode = op[i+1]; end
      else begin A = '0; B = '0; opcode = 2'b11; end
      @(posedge clk); #1;
      checks++;
      if (O !== e[i]) begin
        errors++; $display("FAIL stream[%0d]: got %h want %h", i, O, e[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    A = 32'h3F800000; B = 32'h3F800000; opcode = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1; A = 32'h3FC00000; B = 32'h40000000; opcode = 2'b10;
    @(posedge clk); #1;
    checks++;
    if (O !== 32'h00000000) begin
      errors++; $display("FAIL mid_reset_edge: got %h want 00000000", O);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (O !== 32'h00000000) begin
      errors++; $display("FAIL mid_reset_next: got %h want 00000000", O);
    end
    @(posedge clk); #1;
    checks++;
    if (O !== 32'h40400000) begin
      errors++; $display("FAIL mid_reset_recover: got %h want 40400000", O);
    end
  endtask

  initial begin
    test_reset();
    test_add_tiny();
    test_basic();
    test_specials();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
